// File: rtl/md_pkg.sv
// Shared op codes, FSM encodings and op-class helpers for the multiply/divide unit.
package md_pkg;

  localparam logic [3:0] MD_MULT  = 4'd0;
  localparam logic [3:0] MD_MULTU = 4'd1;
  localparam logic [3:0] MD_DIV   = 4'd2;
  localparam logic [3:0] MD_DIVU  = 4'd3;
  localparam logic [3:0] MD_MTHI  = 4'd4;
  localparam logic [3:0] MD_MTLO  = 4'd5;
  localparam logic [3:0] MD_MADD  = 4'd6;
  localparam logic [3:0] MD_MADDU = 4'd7;
  localparam logic [3:0] MD_MSUB  = 4'd8;
  localparam logic [3:0] MD_MSUBU = 4'd9;

  localparam logic [0:0] MD_IDLE = 1'b0;
  localparam logic [0:0] MD_RUN  = 1'b1;

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Ops that occupy the unit for a multi-cycle busy window.
  function automatic logic md_is_long(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU) ||
           (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational result datapath: produces the shadow HI/LO pair for a long op.
module md_calc import md_pkg::*; #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] shi,
  output logic [WIDTH-1:0] slo,
  output logic             div0
);

  logic [2*WIDTH-1:0] acc, prod_s, prod_u;
  logic [WIDTH-1:0]   a_mag, b_mag, qu_s, ru_s, q_s, r_s, b_safe;

  // Products, magnitude-based signed division and result selection.
  always_comb begin
    acc    = {hi, lo};
    // Sign-extended operands multiplied modulo 2^(2W) give the signed product.
    prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    div0   = md_is_div(op) && (b == '0);
    // A zero divisor is swapped for 1 so the dividers never see it; result is discarded.
    b_safe = div0 ? WIDTH'(1) : b;
    a_mag  = a[WIDTH-1] ? -a : a;
    b_mag  = div0 ? WIDTH'(1) : (b[WIDTH-1] ? -b : b);
    qu_s   = a_mag / b_mag;
    ru_s   = a_mag % b_mag;
    // min / -1 falls out naturally: magnitude 2^(W-1) negated wraps back to min.
    q_s    = (a[WIDTH-1] ^ b[WIDTH-1]) ? -qu_s : qu_s;
    r_s    = a[WIDTH-1] ? -ru_s : ru_s;
    {shi, slo} = acc;
    case (op)
      MD_MULT:  {shi, slo} = prod_s;
      MD_MULTU: {shi, slo} = prod_u;
      MD_DIV: begin
        if (!div0) begin
          slo = q_s;
          shi = r_s;
        end
      end
      MD_DIVU: begin
        if (!div0) begin
          slo = a / b_safe;
          shi = a % b_safe;
        end
      end
      MD_MADD:  {shi, slo} = acc + prod_s;
      MD_MADDU: {shi, slo} = acc + prod_u;
      MD_MSUB:  {shi, slo} = acc - prod_s;
      MD_MSUBU: {shi, slo} = acc - prod_u;
      default:  {shi, slo} = acc;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit: IDLE/RUN FSM, busy counter, shadow result and architectural HI/LO.
module md_unit import md_pkg::*; #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  logic [0:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] shi_q, shi_d, slo_q, slo_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             skip_q, skip_d;
  logic [WIDTH-1:0] calc_hi, calc_lo;
  logic             calc_div0;
  logic             accept;

  md_calc #(
    .WIDTH(WIDTH)
  ) u_calc (
    .op  (op),
    .a   (a),
    .b   (b),
    .hi  (hi_q),
    .lo  (lo_q),
    .shi (calc_hi),
    .slo (calc_lo),
    .div0(calc_div0)
  );

  assign accept = (state_q == MD_IDLE) && start && !cancel;
  assign busy   = (state_q == MD_RUN);
  assign hi     = hi_q;
  assign lo     = lo_q;

  // Next-state: accept ops in IDLE, count down in RUN, commit or drop at the end.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shi_d   = shi_q;
    slo_d   = slo_q;
    skip_d  = skip_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (accept) begin
          if (md_is_long(op)) begin
            shi_d   = calc_hi;
            slo_d   = calc_lo;
            skip_d  = calc_div0;
            cnt_d   = md_is_div(op) ? CntW'(DIV_CYCLES) : CntW'(MUL_CYCLES);
            state_d = MD_RUN;
          end else if (op == MD_MTHI) begin
            hi_d = a;
          end else if (op == MD_MTLO) begin
            lo_d = a;
          end
        end
      end
      MD_RUN: begin
        if (cancel) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
          shi_d   = '0;
          slo_d   = '0;
          skip_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_d = MD_IDLE;
            if (!skip_q) begin
              hi_d = shi_q;
              lo_d = slo_q;
            end
            shi_d  = '0;
            slo_d  = '0;
            skip_d = 1'b0;
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // State registers with asynchronous reset that discards any in-flight op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      shi_q   <= '0;
      slo_q   <= '0;
      skip_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shi_q   <= shi_d;
      slo_q   <= slo_d;
      skip_q  <= skip_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed vector table, hand-written corner sequences, random ops vs model.
module tb_md_unit;

  localparam int MulC = 5;
  localparam int DivC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op_s = 4'd0;
  logic [31:0] a_s = '0;
  logic [31:0] b_s = '0;
  logic        cancel = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  md_unit #(
    .WIDTH     (32),
    .MUL_CYCLES(MulC),
    .DIV_CYCLES(DivC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op_s),
    .a     (a_s),
    .b     (b_s),
    .cancel(cancel),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural {hi,lo} pair.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    longint      sa, sb;
    logic [63:0] acc, ps, pu;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    acc = {m_hi, m_lo};
    ps  = 64'(sa * sb);
    pu  = {32'b0, a} * {32'b0, b};
    lat = 0;
    case (op)
      4'd0: begin {m_hi, m_lo} = ps; lat = MulC; end
      4'd1: begin {m_hi, m_lo} = pu; lat = MulC; end
      4'd2: begin
        if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
        lat = DivC;
      end
      4'd3: begin
        if (b != 0) begin m_lo = a / b; m_hi = a % b; end
        lat = DivC;
      end
      4'd4: m_hi = a;
      4'd5: m_lo = a;
      4'd6: begin {m_hi, m_lo} = acc + ps; lat = MulC; end
      4'd7: begin {m_hi, m_lo} = acc + pu; lat = MulC; end
      4'd8: begin {m_hi, m_lo} = acc - ps; lat = MulC; end
      4'd9: begin {m_hi, m_lo} = acc - pu; lat = MulC; end
      default: lat = 0;
    endcase
  endtask

  // Issue one op, count busy cycles (bounded), then compare latency and hi/lo.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int elat);
    int lat;
    @(negedge clk);
    start = 1'b1; op_s = op; a_s = a; b_s = b;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (busy && lat < 200) begin
      lat++;
      @(negedge clk);
    end
    check({name, ".lat"}, 32'(lat), 32'(elat));
    check({name, ".hi"}, hi, ehi);
    check({name, ".lo"}, lo, elo);
  endtask

  initial begin
    int lat;
    int n;
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    tbl[0]  = '{4'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MulC};
    tbl[1]  = '{4'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, MulC};
    tbl[2]  = '{4'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DivC};
    tbl[3]  = '{4'd4, 32'h00000011, 32'd0,        32'h00000011, 32'hFFFFFFFD, 0};
    tbl[4]  = '{4'd5, 32'h00000022, 32'd0,        32'h00000011, 32'h00000022, 0};
    tbl[5]  = '{4'd3, 32'd7,        32'd0,        32'h00000011, 32'h00000022, DivC};
    tbl[6]  = '{4'd4, 32'd5,        32'd0,        32'h00000005, 32'h00000022, 0};
    tbl[7]  = '{4'd5, 32'd1,        32'd0,        32'h00000005, 32'h00000001, 0};
    tbl[8]  = '{4'd6, 32'd2,        32'd3,        32'h00000005, 32'h00000007, MulC};
    tbl[9]  = '{4'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DivC};
    tbl[10] = '{4'd12, 32'hAAAA5555, 32'h1234,    32'h00000000, 32'h80000000, 0};
    tbl[11] = '{4'd8, 32'd1,        32'd1,        32'h00000000, 32'h7FFFFFFF, MulC};
    tbl[12] = '{4'd9, 32'd2,        32'd1,        32'h00000000, 32'h7FFFFFFD, MulC};
    tbl[13] = '{4'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h7FFFFFFE, MulC};
    tbl[14] = '{4'd3, 32'd7,        32'd2,        32'h00000001, 32'h00000003, DivC};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.hi", hi, 32'd0);
    check("reset.lo", lo, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo,
             tbl[i].lat);
    end
    m_hi = 32'h1;
    m_lo = 32'h3;

    // Cancel on busy cycle 3: no commit, busy drops next cycle.
    @(negedge clk);
    start = 1'b1; op_s = 4'd0; a_s = 32'd7; b_s = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("cancel3.busy_before", 32'(busy), 32'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel3.busy", 32'(busy), 32'd0);
    check("cancel3.hi", hi, m_hi);
    check("cancel3.lo", lo, m_lo);
    repeat (8) @(negedge clk);
    check("cancel3.lo_late", lo, m_lo);

    // Cancel on the final busy cycle still wins.
    @(negedge clk);
    start = 1'b1; op_s = 4'd1; a_s = 32'd100; b_s = 32'd100;
    @(negedge clk);
    start = 1'b0;
    repeat (MulC - 1) @(negedge clk);
    check("cancel_last.busy_before", 32'(busy), 32'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_last.busy", 32'(busy), 32'd0);
    check("cancel_last.lo", lo, m_lo);
    check("cancel_last.hi", hi, m_hi);

    // Start while busy is ignored.
    @(negedge clk);
    start = 1'b1; op_s = 4'd0; a_s = 32'd3; b_s = 32'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op_s = 4'd4; a_s = 32'hDEAD;
    @(negedge clk);
    start = 1'b0;
    check("busy_start.hi_hold", hi, m_hi);
    lat = 2;
    while (busy && lat < 200) begin
      lat++;
      @(negedge clk);
    end
    model(4'd0, 32'd3, 32'd4, n);
    check("busy_start.lat", 32'(lat), 32'(n));
    check("busy_start.hi", hi, m_hi);
    check("busy_start.lo", lo, m_lo);

    // Cancel with start in IDLE drops the op, MTHI included.
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op_s = 4'd4; a_s = 32'hABCD;
    @(negedge clk);
    check("idle_cancel.hi", hi, m_hi);
    op_s = 4'd0;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("idle_cancel.busy", 32'(busy), 32'd0);

    // Async reset mid-RUN.
    model(4'd4, 32'h77, 32'd0, n);
    run_op("pre_reset_mthi", 4'd4, 32'h77, 32'd0, m_hi, m_lo, n);
    @(negedge clk);
    start = 1'b1; op_s = 4'd0; a_s = 32'd5; b_s = 32'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_run.busy", 32'(busy), 32'd0);
    check("reset_run.hi", hi, 32'd0);
    check("reset_run.lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;

    // Random ops against the model.
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 11));
      ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      else if ($urandom_range(0, 1) == 1) rb = $urandom;
      else rb = 32'($urandom_range(0, 15)) - 32'd7;
      model(rop, ra, rb, n);
      run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, m_hi, m_lo, n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
